// File: rtl/garegga_snd_cmd_tx_if.sv
// rtl/garegga_snd_cmd_tx_if.sv - 68k write port, Z80 handshake and status signals of the sound command transmitter
interface garegga_snd_cmd_tx_if #(
  parameter int AW = 2
);
  logic          WR_STB;
  logic [7:0]    WR_DATA;
  logic          CLR_ERR;
  logic          WAIT;
  logic [7:0]    SOUNDLATCH;
  logic          Z80INT;
  logic          BUSY;
  logic [AW:0]   FIFO_COUNT;
  logic          FULL;
  logic          OVERFLOW;
  logic          TIMEOUT_ERR;

  modport master (
    output WR_STB, WR_DATA, CLR_ERR, WAIT,
    input  SOUNDLATCH, Z80INT, BUSY, FIFO_COUNT, FULL, OVERFLOW, TIMEOUT_ERR
  );

  modport slave (
    input  WR_STB, WR_DATA, CLR_ERR, WAIT,
    output SOUNDLATCH, Z80INT, BUSY, FIFO_COUNT, FULL, OVERFLOW, TIMEOUT_ERR
  );
endinterface

// File: rtl/garegga_snd_cmd_tx.sv
// rtl/garegga_snd_cmd_tx.sv - 68k-side sound command FIFO and Z80 handshake transmitter
// Queues command bytes and delivers each one on SOUNDLATCH with a Z80INT pulse and WAIT ack.
module garegga_snd_cmd_tx #(
  parameter int DEPTH   = 4,
  parameter int INT_LEN = 4,
  parameter int GAP     = 8,
  parameter int TIMEOUT = 1048576
) (
  input logic                 CLK96,
  input logic                 RESET96,
  garegga_snd_cmd_tx_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int TMAX0 = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int TMAX  = (TMAX0 > INT_LEN) ? TMAX0 : INT_LEN;
  localparam int TW    = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0] INT_LOAD = TW'(INT_LEN - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_SET,
    S_WAIT_CLR,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_n;
  logic            int_q;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;
  logic [7:0]      latch;
  logic            ovf_q;
  logic            to_q;

  logic            pop;
  logic            push;
  logic            ovf_evt;
  logic            to_evt;
  logic            to_hit;
  logic            busy;
  logic            full;

  // A full FIFO still accepts a write in the cycle the FSM pops its head.
  assign push    = bus.WR_STB && ((count != FULL_CNT) || pop);
  assign ovf_evt = bus.WR_STB && !push;
  assign to_hit  = (TIMEOUT != 0) && (timer == '0);

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      state <= S_IDLE;
      timer <= '0;
      int_q <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      int_q <= (state_n == S_ASSERT);
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    pop     = 1'b0;
    to_evt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_n = S_ASSERT;
          timer_n = INT_LOAD;
        end
      end
      S_ASSERT: begin
        if (timer == '0) begin
          state_n = S_WAIT_SET;
          timer_n = TO_LOAD;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      S_WAIT_SET: begin
        if (bus.WAIT) begin
          state_n = S_WAIT_CLR;
          timer_n = TO_LOAD;
        end else if (to_hit) begin
          to_evt  = 1'b1;
          state_n = (GAP == 0) ? S_IDLE : S_GAP;
          timer_n = GAP_LOAD;
        end else if (timer != '0) begin
          timer_n = timer - 1'b1;
        end
      end
      S_WAIT_CLR: begin
        if (!bus.WAIT || to_hit) begin
          to_evt  = bus.WAIT;
          state_n = (GAP == 0) ? S_IDLE : S_GAP;
          timer_n = GAP_LOAD;
        end else if (timer != '0) begin
          timer_n = timer - 1'b1;
        end
      end
      S_GAP: begin
        if (timer == '0) begin
          state_n = S_IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE) || (count != '0);
    full = (count == FULL_CNT);
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      latch <= '0;
      ovf_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= bus.WR_DATA;
        wptr      <= wptr + 1'b1;
      end
      if (pop) begin
        latch <= mem[rptr];
        rptr  <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error event outranks a simultaneous clear.
      if (ovf_evt) begin
        ovf_q <= 1'b1;
      end else if (bus.CLR_ERR) begin
        ovf_q <= 1'b0;
      end
      if (to_evt) begin
        to_q <= 1'b1;
      end else if (bus.CLR_ERR) begin
        to_q <= 1'b0;
      end
    end
  end

  assign bus.SOUNDLATCH  = latch;
  assign bus.Z80INT      = int_q;
  assign bus.BUSY        = busy;
  assign bus.FIFO_COUNT  = count;
  assign bus.FULL        = full;
  assign bus.OVERFLOW    = ovf_q;
  assign bus.TIMEOUT_ERR = to_q;

endmodule

// File: tb/tb_garegga_snd_cmd_tx.sv
// tb/tb_garegga_snd_cmd_tx.sv - scoreboard bench for the sound command transmitter
module tb_garegga_snd_cmd_tx;

  localparam int DEPTH   = 4;
  localparam int INT_LEN = 4;
  localparam int GAP     = 8;
  localparam int TIMEOUT = 64;
  localparam int AW      = 2;

  logic CLK96   = 1'b0;
  logic RESET96 = 1'b1;

  garegga_snd_cmd_tx_if #(.AW(AW)) bus ();

  garegga_snd_cmd_tx #(
    .DEPTH  (DEPTH),
    .INT_LEN(INT_LEN),
    .GAP    (GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK96  (CLK96),
    .RESET96(RESET96),
    .bus    (bus)
  );

  always #5 CLK96 = ~CLK96;

  int         total  = 0;
  int         passed = 0;
  logic [7:0] exp_q[$];

  bit ack_en    = 1'b0;
  int ack_delay = 1;
  int ack_hold  = 20;

  bit r_busy    = 1'b0;
  bit r_handled = 1'b0;
  int r_cnt     = 0;
  int r_hold    = 0;

  logic       m_prev_int   = 1'b0;
  logic [7:0] m_prev_latch = 8'h00;
  int         m_width      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK96);
  endtask

  task automatic wr(input logic [7:0] d, input bit accept);
    bus.WR_STB  = 1'b1;
    bus.WR_DATA = d;
    if (accept) exp_q.push_back(d);
    @(negedge CLK96);
    bus.WR_STB = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_latch"}, bus.SOUNDLATCH, 0);
    chk({tag, "_int"}, bus.Z80INT, 0);
    chk({tag, "_busy"}, bus.BUSY, 0);
    chk({tag, "_count"}, bus.FIFO_COUNT, 0);
    chk({tag, "_full"}, bus.FULL, 0);
    chk({tag, "_ovf"}, bus.OVERFLOW, 0);
    chk({tag, "_tmo"}, bus.TIMEOUT_ERR, 0);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge CLK96);
      if (!bus.BUSY) break;
    end
    chk(name, (i < budget), 1);
  endtask

  task automatic wait_count(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge CLK96);
      if (bus.FIFO_COUNT == n) break;
    end
    chk(name, (i < budget), 1);
  endtask

  // Write 0x5A-style single command, ack 20 cycles, then 8 gap cycles before BUSY drops.
  task automatic single_cmd(input logic [7:0] d, input string tag);
    ack_en    = 1'b1;
    ack_delay = 1;
    ack_hold  = 20;
    wr(d, 1'b1);
    chk({tag, "_count1"}, bus.FIFO_COUNT, 1);
    chk({tag, "_busy1"}, bus.BUSY, 1);
    tick(1);
    chk({tag, "_latch"}, bus.SOUNDLATCH, d);
    chk({tag, "_int"}, bus.Z80INT, 1);
    chk({tag, "_count0"}, bus.FIFO_COUNT, 0);
    tick(29);
    chk({tag, "_busy_gap"}, bus.BUSY, 1);
    tick(1);
    chk({tag, "_busy_idle"}, bus.BUSY, 0);
  endtask

  // Sound-block model: raises WAIT some cycles after a Z80INT pulse starts and holds it.
  initial begin
    bus.WAIT = 1'b0;
    forever begin
      @(negedge CLK96);
      if (RESET96) begin
        bus.WAIT  = 1'b0;
        r_busy    = 1'b0;
        r_handled = 1'b0;
      end else begin
        if (!bus.Z80INT) r_handled = 1'b0;
        if (r_busy) begin
          r_cnt++;
          if (r_cnt == ack_delay) bus.WAIT = 1'b1;
          if (r_cnt == ack_delay + r_hold) begin
            bus.WAIT = 1'b0;
            r_busy   = 1'b0;
          end
        end else if (ack_en && bus.Z80INT && !r_handled) begin
          r_busy    = 1'b1;
          r_handled = 1'b1;
          r_cnt     = 0;
          r_hold    = ack_hold;
        end
      end
    end
  end

  // Monitor: each Z80INT rise pops the next expected byte; latch may only change on that rise.
  initial begin
    forever begin
      @(negedge CLK96);
      if (RESET96) begin
        m_prev_int   = 1'b0;
        m_width      = 0;
        m_prev_latch = bus.SOUNDLATCH;
      end else begin
        if (bus.Z80INT && !m_prev_int) begin
          if (exp_q.size() == 0) chk("unexpected_int_queue_depth", exp_q.size(), 1);
          else chk("latch_order", bus.SOUNDLATCH, exp_q.pop_front());
        end
        if (bus.SOUNDLATCH != m_prev_latch)
          chk("latch_change_at_int", {31'b0, bus.Z80INT && !m_prev_int}, 1);
        if (!bus.Z80INT && m_prev_int) chk("int_width", m_width, INT_LEN);
        m_width      = bus.Z80INT ? m_width + 1 : 0;
        m_prev_int   = bus.Z80INT;
        m_prev_latch = bus.SOUNDLATCH;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  initial begin
    bus.WR_STB  = 1'b0;
    bus.WR_DATA = 8'h00;
    bus.CLR_ERR = 1'b0;
    RESET96     = 1'b1;
    tick(3);
    check_all_zero("rst");
    RESET96 = 1'b0;
    tick(2);

    single_cmd(8'h5A, "single");

    ack_hold = 30;
    for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
    chk("burst_count", bus.FIFO_COUNT, 4);
    chk("burst_full", bus.FULL, 1);
    chk("burst_ovf", bus.OVERFLOW, 0);
    wait_idle(600, "burst_drain");
    chk("burst_all_out", exp_q.size(), 0);

    ack_en = 1'b0;
    for (int i = 1; i <= 5; i++) wr(8'hC0 + 8'(i), 1'b1);
    tick(3);
    wr(8'h99, 1'b0);
    chk("ovf_set", bus.OVERFLOW, 1);
    chk("ovf_count", bus.FIFO_COUNT, 4);
    bus.CLR_ERR = 1'b1;
    tick(1);
    bus.CLR_ERR = 1'b0;
    chk("ovf_clr", bus.OVERFLOW, 0);
    bus.WR_STB  = 1'b1;
    bus.WR_DATA = 8'h98;
    bus.CLR_ERR = 1'b1;
    tick(1);
    bus.WR_STB  = 1'b0;
    bus.CLR_ERR = 1'b0;
    chk("ovf_err_wins", bus.OVERFLOW, 1);
    bus.CLR_ERR = 1'b1;
    tick(1);
    bus.CLR_ERR = 1'b0;
    chk("ovf_clr2", bus.OVERFLOW, 0);

    tick(57);
    chk("tmo_before", bus.TIMEOUT_ERR, 0);
    tick(1);
    chk("tmo_set", bus.TIMEOUT_ERR, 1);
    tick(8);
    chk("tmo_gap_int", bus.Z80INT, 0);
    tick(1);
    chk("tmo_next_int", bus.Z80INT, 1);
    chk("tmo_next_latch", bus.SOUNDLATCH, 8'hC2);
    chk("tmo_next_count", bus.FIFO_COUNT, 3);

    wr(8'h44, 1'b1);
    chk("pp_pre_count", bus.FIFO_COUNT, 4);
    chk("pp_pre_full", bus.FULL, 1);
    tick(75);
    chk("pp_idle_int", bus.Z80INT, 0);
    wr(8'h77, 1'b1);
    chk("pp_count", bus.FIFO_COUNT, 4);
    chk("pp_ovf", bus.OVERFLOW, 0);
    chk("pp_int", bus.Z80INT, 1);

    ack_delay = 1;
    ack_hold  = 6;
    ack_en    = 1'b1;
    wait_count(3, 200, "rst_wait_c4");
    tick(2);
    ack_hold = 40;
    wait_count(2, 200, "rst_wait_c5");
    tick(8);
    chk("rst_pre_int", bus.Z80INT, 0);
    chk("rst_pre_count", bus.FIFO_COUNT, 2);
    chk("rst_pre_busy", bus.BUSY, 1);
    #2 RESET96 = 1'b1;
    #1 check_all_zero("rst_mid");
    exp_q.delete();
    tick(2);
    RESET96 = 1'b0;
    tick(10);
    chk("rst_after_busy", bus.BUSY, 0);
    chk("rst_after_int", bus.Z80INT, 0);

    single_cmd(8'h3C, "post_rst");
    tick(2);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/garegga_snd_cmd_tx.md
Name: garegga_snd_cmd_tx

Overview:
- 68000-side transmitter for the sound-command path.
- Queues command bytes written by the main CPU in a small FIFO and presents each byte on SOUNDLATCH.
- Raises a Z80INT pulse per byte, then holds the byte until the sound block's WAIT flag rises and then clears (Z80 wrote its ack).
- Replaces direct latch writes, so back-to-back 68k commands are not lost while the Z80 is still servicing one.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2. AW = log2(DEPTH).
- INT_LEN, 4, CLK96 cycles Z80INT is held high per command; minimum 1.
- GAP, 8, idle CLK96 cycles after an ack before the next command is presented.
- TIMEOUT, 1048576, CLK96 cycles allowed in each wait state before abort. 0 disables the timeout.

Ports:
- CLK96  in  1  system clock.
- RESET96  in  1  asynchronous, active-high reset.
- WR_STB  in  1  single-cycle write strobe from the 68k decode.
- WR_DATA  in  8  command byte, sampled when WR_STB=1.
- CLR_ERR  in  1  clears the sticky OVERFLOW and TIMEOUT_ERR flags.
- WAIT  in  1  pending flag from the sound block: set by the Z80INT edge, cleared by the Z80 ack write.
- SOUNDLATCH  out  8  byte presented to the Z80.
- Z80INT  out  1  interrupt pulse to the sound block (rising edge is significant).
- BUSY  out  1  high when the FSM is not IDLE or the FIFO is not empty.
- FIFO_COUNT  out  AW+1  number of queued bytes, excluding the byte currently on SOUNDLATCH.
- FULL  out  1  FIFO_COUNT==DEPTH.
- OVERFLOW  out  1  sticky: a write was dropped.
- TIMEOUT_ERR  out  1  sticky: a handshake timed out.

Behaviour:
Reset (async, RESET96=1):
- SOUNDLATCH=0, Z80INT=0, BUSY=0, FIFO_COUNT=0, FULL=0, OVERFLOW=0, TIMEOUT_ERR=0.
- FSM enters IDLE; read/write pointers, the timer and the FIFO contents are 0.
- Reset mid-handshake abandons the byte with no further Z80INT edge.

FIFO:
- Circular buffer with AW-bit pointers that wrap modulo DEPTH.
- Push when WR_STB=1 and (count<DEPTH, or a pop occurs in the same cycle).
- When count==DEPTH and no pop occurs that cycle, WR_STB sets OVERFLOW and the byte is dropped.
- Push and pop in the same cycle leave the count unchanged; the data are still ordered correctly.
- A byte written into an empty FIFO while in IDLE is visible to the FSM on the next cycle. Write-to-SOUNDLATCH latency is 2 cycles.

FSM (all transitions on the CLK96 rising edge):
- IDLE:
  - If count>0: pop the head into SOUNDLATCH, load timer=INT_LEN-1, go to ASSERT.
  - Otherwise stay in IDLE.
- ASSERT:
  - Z80INT=1.
  - Timer decrements; at 0 go to WAIT_SET and load the timeout timer.
- WAIT_SET:
  - Z80INT=0; waits for WAIT=1.
  - When WAIT=1, go to WAIT_CLR and reload the timeout timer.
- WAIT_CLR:
  - Waits for WAIT=0.
  - When WAIT=0, go to GAP_ST with timer=GAP-1.
- GAP_ST:
  - Timer decrements; at 0 go to IDLE.
  - GAP=0 goes directly to IDLE.

Timeout:
- Applies in WAIT_SET and WAIT_CLR only.
- When the timer expires: set TIMEOUT_ERR, go to GAP_ST; the byte is considered delivered.

Outputs and flags:
- Z80INT is a registered output, high exactly INT_LEN consecutive cycles per command.
- SOUNDLATCH changes only on the IDLE->ASSERT transition and is stable through every handshake state.
- If WAIT is already 1 when ASSERT is entered (stale flag), the FSM still requires a full 1->0 transition in WAIT_CLR; no special case.
- CLR_ERR and a new error event in the same cycle: the error wins and the flag stays 1.
- BUSY and FULL are combinational from the registered state and count.
- Sound-block timing: the sound block sees the Z80INT rising edge on the next CLK96 edge, so WAIT rises no earlier than the second ASSERT cycle.

Test Plan:
- Single command: WR_STB with 0x5A in IDLE.
  - SOUNDLATCH=0x5A two cycles later; Z80INT high for 4 cycles.
  - Drive WAIT=1 for 20 cycles, then 0: FSM passes WAIT_CLR, then GAP_ST for 8 cycles; BUSY falls in the IDLE cycle.
- Burst: write 0x01,0x02,0x03,0x04,0x05 on consecutive cycles while the ack is delayed.
  - FIFO_COUNT reaches 4 and FULL=1 after 0x05; no overflow, since 0x01 was popped.
  - The five bytes appear on SOUNDLATCH in order, one Z80INT pulse each.
- Overflow: with the FSM stuck in WAIT_SET and 4 bytes queued, write 0x99.
  - OVERFLOW=1, FIFO_COUNT stays 4, and 0x99 never appears on SOUNDLATCH.
  - CLR_ERR then returns OVERFLOW=0.
- Timeout: TIMEOUT=64, WAIT held at 0 after Z80INT.
  - 64 cycles later TIMEOUT_ERR=1, the FSM goes through GAP_ST, and the next queued byte is presented.
- Push/pop same cycle: FIFO full with the FSM entering IDLE.
  - A WR_STB in the pop cycle is accepted; FIFO_COUNT stays 4 and OVERFLOW stays 0.
- Async reset asserted in WAIT_CLR with 2 bytes queued.
  - All outputs are 0 immediately, with no Z80INT pulse after release.
  - A new write after release follows the single-command sequence.
